// File: rtl/mem_stage_if.sv
// Data-memory port bundle between the MEM stage and the data memory.
//   master : the MEM stage; drives the request, address, enables and store data
//   slave  : the memory; returns ack and load data
// dmem_rdata is valid in the same cycle as dmem_ack on a load.
interface mem_stage_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    output dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/mem_stage.sv
// Memory-access stage of the five-stage pipeline.
// Holds the EX/MEM pipeline register, runs loads/stores over a req/ack port,
// aligns and extends load data, and provides the MEM forwarding value.
//
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-low reset
//   EX_alu_res      ALU result / byte address
//   EX_mem_din      store data
//   EX_vld          execute result valid
//   EX_mem_ctrl     [4:3] op (01 load, 10 store, else none), [2:1] size, [0] unsigned
//   dmem            data-memory port (master side)
//   MEM_data        stage result to write-back and the EX forwarding mux
//   MEM_vld         MEM_data valid
//   MEM_misaligned  held instruction is a misaligned load/store
//   MEM_busy        stall upstream; EX/MEM register holds
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no access in flight; P holds a non-memory or misaligned op
// WAIT  | request on the bus, waiting for dmem_ack; upstream stalled
// RESP  | access done; MEM_data carries load data or the store address
module mem_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] EX_alu_res,
  input  logic [31:0] EX_mem_din,
  input  logic        EX_vld,
  input  logic [4:0]  EX_mem_ctrl,
  mem_stage_if.master dmem,
  output logic [31:0] MEM_data,
  output logic        MEM_vld,
  output logic        MEM_misaligned,
  output logic        MEM_busy
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_STORE = 2'b10;
  localparam logic [1:0] SZ_BYTE  = 2'b00;
  localparam logic [1:0] SZ_HALF  = 2'b01;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return lo[0];
      default: return lo != 2'b00;
    endcase
  endfunction

  state_t      state_q, state_d;
  logic        p_vld_q, p_vld_d;
  logic [31:0] p_addr_q, p_addr_d;
  logic [31:0] p_din_q, p_din_d;
  logic [4:0]  p_ctrl_q, p_ctrl_d;
  logic [31:0] ld_q, ld_d;

  logic        ex_mem_op, ex_mis;
  logic        p_is_load, p_is_store, p_mem_op, p_mis;
  logic [3:0]  be_calc;
  logic [31:0] wdata_calc;
  logic [31:0] ld_fmt;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      p_vld_q  <= 1'b0;
      p_addr_q <= '0;
      p_din_q  <= '0;
      p_ctrl_q <= '0;
      ld_q     <= '0;
    end else begin
      state_q  <= state_d;
      p_vld_q  <= p_vld_d;
      p_addr_q <= p_addr_d;
      p_din_q  <= p_din_d;
      p_ctrl_q <= p_ctrl_d;
      ld_q     <= ld_d;
    end
  end

  // Lane steering and load formatting, all from the held P register.
  always_comb begin
    ex_mem_op  = (EX_mem_ctrl[4:3] == OP_LOAD) || (EX_mem_ctrl[4:3] == OP_STORE);
    ex_mis     = is_misaligned(EX_mem_ctrl[2:1], EX_alu_res[1:0]);
    p_is_load  = p_ctrl_q[4:3] == OP_LOAD;
    p_is_store = p_ctrl_q[4:3] == OP_STORE;
    p_mem_op   = p_is_load || p_is_store;
    p_mis      = is_misaligned(p_ctrl_q[2:1], p_addr_q[1:0]);

    case (p_ctrl_q[2:1])
      SZ_BYTE: begin
        be_calc    = 4'b0001 << p_addr_q[1:0];
        wdata_calc = {4{p_din_q[7:0]}};
      end
      SZ_HALF: begin
        be_calc    = 4'b0011 << p_addr_q[1:0];
        wdata_calc = {2{p_din_q[15:0]}};
      end
      default: begin
        be_calc    = 4'b1111;
        wdata_calc = p_din_q;
      end
    endcase

    case (p_addr_q[1:0])
      2'd0:    byte_sel = dmem.dmem_rdata[7:0];
      2'd1:    byte_sel = dmem.dmem_rdata[15:8];
      2'd2:    byte_sel = dmem.dmem_rdata[23:16];
      default: byte_sel = dmem.dmem_rdata[31:24];
    endcase
    half_sel = p_addr_q[1] ? dmem.dmem_rdata[31:16] : dmem.dmem_rdata[15:0];

    case (p_ctrl_q[2:1])
      SZ_BYTE: ld_fmt = p_ctrl_q[0] ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      SZ_HALF: ld_fmt = p_ctrl_q[0] ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
      default: ld_fmt = dmem.dmem_rdata;
    endcase
  end

  // Next state and outputs.
  always_comb begin
    state_d  = state_q;
    p_vld_d  = p_vld_q;
    p_addr_d = p_addr_q;
    p_din_d  = p_din_q;
    p_ctrl_d = p_ctrl_q;
    ld_d     = ld_q;

    dmem.dmem_req   = 1'b0;
    dmem.dmem_we    = 1'b0;
    dmem.dmem_be    = 4'b0000;
    dmem.dmem_addr  = {p_addr_q[31:2], 2'b00};
    dmem.dmem_wdata = wdata_calc;
    MEM_data        = p_addr_q;
    MEM_vld         = 1'b0;
    MEM_misaligned  = 1'b0;
    MEM_busy        = 1'b0;

    case (state_q)
      S_WAIT: begin
        dmem.dmem_req = 1'b1;
        dmem.dmem_we  = p_is_store;
        dmem.dmem_be  = be_calc;
        MEM_busy      = 1'b1;
        if (dmem.dmem_ack) begin
          ld_d    = ld_fmt;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        MEM_vld  = 1'b1;
        MEM_data = p_is_load ? ld_q : p_addr_q;
      end
      default: begin
        MEM_vld        = p_vld_q & ~(p_mem_op & p_mis);
        MEM_misaligned = p_vld_q & p_mem_op & p_mis;
      end
    endcase

    // P reloads whenever the stage is not stalled; RESP of one op and the
    // load of the next share an edge, so memory ops run back to back.
    if (state_q != S_WAIT) begin
      p_vld_d  = EX_vld;
      p_addr_d = EX_alu_res;
      p_din_d  = EX_mem_din;
      p_ctrl_d = EX_mem_ctrl;
      state_d  = (EX_vld && ex_mem_op && !ex_mis) ? S_WAIT : S_IDLE;
    end
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the five-stage pipeline, directly downstream of the execute stage. It registers the execute-stage result (the EX/MEM pipeline register) and performs loads and stores over a req/ack data-memory port. Load data is aligned and extended before it is passed to write-back. It produces the MEM-stage forwarding value used by the execute stage's operand muxes, and raises a stall while a memory access is outstanding.

## Interface
- Parameters: none (datapath fixed at 32 bits).
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- EX_alu_res  in  32  ALU result; byte address for loads/stores
- EX_mem_din  in  32  store data (rs2 after forwarding)
- EX_vld  in  1  execute result valid
- EX_mem_ctrl  in  5  [4:3] op (00 none, 01 load, 10 store, 11 none); [2:1] size (00 byte, 01 half, 10 word, 11 word); [0] unsigned load
- dmem_req  out  1  access request
- dmem_we  out  1  1 = store
- dmem_addr  out  32  word address: {P_addr[31:2],2'b00}
- dmem_be  out  4  byte enables
- dmem_wdata  out  32  lane-replicated store data
- dmem_ack  in  1  access complete; rdata valid the same cycle for loads
- dmem_rdata  in  32  load word
- MEM_data  out  32  stage result (to write-back and the EX forwarding mux F1)
- MEM_vld  out  1  MEM_data valid
- MEM_misaligned  out  1  held instruction is a misaligned load/store
- MEM_busy  out  1  stall upstream; EX/MEM register holds

## Operation
- Pipeline register P {vld, addr, din, ctrl} loads from the EX_* inputs on every rising edge when MEM_busy=0. It holds when MEM_busy=1.
- Misaligned conditions: half with addr[0]=1, or word with addr[1:0]≠00. A misaligned op issues no bus access.
- FSM states: IDLE, WAIT, RESP.
- On each P load:
  - next state = WAIT if the incoming EX_vld=1, op is load or store, and the op is aligned;
  - otherwise next state = IDLE.
- IDLE:
  - dmem_req=0, MEM_busy=0.
  - MEM_data=P.addr; MEM_vld=P.vld & ~misaligned_mem_op.
  - MEM_misaligned=P.vld & mem op & misaligned.
- WAIT:
  - dmem_req=1, MEM_busy=1, MEM_vld=0.
  - dmem_addr, dmem_we, dmem_be and dmem_wdata are stable for the whole state.
  - On dmem_ack: capture formatted load data into LD, then go to RESP.
- RESP:
  - MEM_busy=0, MEM_vld=1.
  - MEM_data = LD for a load, P.addr for a store.
  - Leaves RESP on the next edge per the P-load rule.
- Store byte enables:
  - byte: 0001<<addr[1:0];
  - half: 0011<<addr[1:0];
  - word: 1111.
- Store wdata: byte = {4{din[7:0]}}; half = {2{din[15:0]}}; word = din.
- Load formatting:
  - byte lane selected by addr[1:0], half lane selected by addr[1];
  - zero-extend when ctrl[0]=1, sign-extend otherwise.
- dmem_be=0000 and dmem_we=0 when dmem_req=0.

## Timing
- Reset (rst=0, asynchronous): state IDLE, P cleared (vld=0, ctrl op none), LD=0.
  - Outputs during reset: dmem_req=0, dmem_we=0, dmem_be=0, MEM_vld=0, MEM_busy=0, MEM_misaligned=0, MEM_data=0.
- Reset asserted mid-WAIT: dmem_req drops immediately and the access is abandoned.
- Non-memory op: result visible on MEM_data 1 cycle after EX, and MEM_busy is never asserted.
- Memory op:
  - If ack arrives in the first WAIT cycle, the op spends 2 cycles in the stage (WAIT, RESP) and MEM_busy is high for 1 cycle.
  - Each extra cycle without ack adds one WAIT cycle.
- dmem_ack is ignored outside WAIT.
- Back-to-back memory ops: RESP of op N and the P load of op N+1 happen on the same edge, so there is no idle bubble.
- The execute stage must not forward MEM_data while MEM_vld=0. A load-use hazard is resolved by the hazard unit.

## Test plan
- Word load:
  - Stimulus: EX_alu_res=0x100, op=load, size=word; ack in the first WAIT cycle with rdata=0xDEADBEEF.
  - Required: dmem_addr=0x100, be=1111; MEM_busy high for 1 cycle; the next cycle has MEM_data=0xDEADBEEF, MEM_vld=1.
- Byte loads:
  - Stimulus: addr=0x103, rdata=0x80AABBCC, with ctrl[0]=0, then ctrl[0]=1.
  - Required: MEM_data=0xFFFFFF80 (signed), then 0x00000080 (unsigned).
- Half store:
  - Stimulus: addr=0x202, din=0x1234ABCD.
  - Required: dmem_we=1, be=1100, wdata=0xABCDABCD, dmem_addr=0x200; RESP has MEM_data=0x202.
- Wait states and stall:
  - Stimulus: ack delayed 3 cycles.
  - Required: 3 WAIT cycles with req/addr/be stable and MEM_busy=1; the upstream value presented during the stall is captured only after RESP; there is no bubble between consecutive loads.
- Misaligned access:
  - Stimulus: a word load at 0x105.
  - Required: dmem_req stays 0; MEM_misaligned=1 and MEM_vld=0 for 1 cycle.
- Async reset:
  - Stimulus: rst asserted during WAIT.
  - Required: dmem_req and MEM_busy go to 0 immediately; after release the stage is in IDLE with MEM_vld=0.
